// File: rtl/enemy_pkg.sv
// rtl/enemy_pkg.sv - shared constants, FSM encoding and LFSR step for the enemy spawn controller
package enemy_pkg;

   localparam int N_SLOTS    = 10;
   localparam int SLOT_IDX_W = 4;
   localparam int LIVES_W    = 2;

   localparam logic [7:0] X_OFFSET = 8'd8;
   localparam logic [6:0] X_MASK   = 7'h7F;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_COUNT = 2'd1;
   localparam logic [1:0] ST_PICK  = 2'd2;
   localparam logic [1:0] ST_SPAWN = 2'd3;

   // 8-bit Fibonacci LFSR, taps 8,6,5,4
   function automatic logic [7:0] lfsr_next(input logic [7:0] l);
      return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
   endfunction

endpackage

// File: rtl/slot_pick_enc.sv
// rtl/slot_pick_enc.sv - lowest-index free slot priority encoder
module slot_pick_enc
   import enemy_pkg::*;
(
   input  logic [N_SLOTS-1:0]    used,
   output logic [SLOT_IDX_W-1:0] idx,
   output logic                  none_free
);

   always_comb begin
      idx       = '0;
      none_free = 1'b1;
      // Scan downwards so the lowest free index is the last one written
      for (int i = N_SLOTS - 1; i >= 0; i--) begin
         if (!used[i]) begin
            idx       = SLOT_IDX_W'(i);
            none_free = 1'b0;
         end
      end
   end

endmodule

// File: rtl/enemy_spawn_ctrl.sv
// rtl/enemy_spawn_ctrl.sv - enemy slot owner: timed spawns, slot freeing, kills/lives/game over
// Optional DIFFICULTY_RAMP_EN: flying_rate follows kill_count instead of base_rate.
module enemy_spawn_ctrl
   import enemy_pkg::*;
#(
   parameter logic [23:0]        SPAWN_PERIOD = 24'd12499999,
   parameter logic [7:0]         LFSR_SEED    = 8'hA5,
   parameter logic [LIVES_W-1:0] LIVES_INIT   = 2'd3
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   game_en,
   input  logic [N_SLOTS-1:0]     hit,
   input  logic [N_SLOTS-1:0]     touch_edge,
   input  logic [1:0]             base_rate,
   output logic [N_SLOTS-1:0]     c_en,
   output logic [N_SLOTS-1:0]     des,
   output logic [8*N_SLOTS-1:0]   x_flat,
   output logic [1:0]             flying_rate,
   output logic [7:0]             kill_count,
   output logic [LIVES_W-1:0]     lives,
   output logic                   game_over,
   output logic                   spawn_drop
);

   logic [1:0]                  state_q, state_d;
   logic [23:0]                 timer_q, timer_d;
   logic [7:0]                  lfsr_q, lfsr_d;
   logic [SLOT_IDX_W-1:0]       pick_q, pick_d;
   logic [N_SLOTS-1:0]          c_en_q, c_en_d;
   logic [N_SLOTS-1:0]          des_q, des_d;
   logic [N_SLOTS-1:0][7:0]     x_q, x_d;
   logic [7:0]                  kill_q, kill_d;
   logic [LIVES_W-1:0]          lives_q, lives_d;
   logic                        over_q, over_d;
   logic                        drop_q, drop_d;

   logic [SLOT_IDX_W-1:0]       free_idx;
   logic                        none_free;
   logic [3:0]                  kills;
   logic [3:0]                  escapes;
   logic [8:0]                  kill_sum;
   logic                        run;

   slot_pick_enc u_pick (
      .used      (c_en_q),
      .idx       (free_idx),
      .none_free (none_free)
   );

   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      lfsr_d   = lfsr_next(lfsr_q);
      pick_d   = pick_q;
      c_en_d   = c_en_q;
      des_d    = '0;
      x_d      = x_q;
      kill_d   = kill_q;
      lives_d  = lives_q;
      over_d   = over_q;
      drop_d   = 1'b0;
      kills    = '0;
      escapes  = '0;
      kill_sum = '0;
      run      = game_en && !over_q;

      // A simultaneous hit and edge touch is credited as a kill
      for (int i = 0; i < N_SLOTS; i++) begin
         if (c_en_q[i] && (hit[i] || touch_edge[i])) begin
            c_en_d[i] = 1'b0;
            des_d[i]  = 1'b1;
            if (hit[i]) kills = kills + 4'd1;
            else        escapes = escapes + 4'd1;
         end
      end

      kill_sum = {1'b0, kill_q} + {5'b0, kills};
      kill_d   = kill_sum[8] ? 8'hFF : kill_sum[7:0];

      if (escapes != 4'd0) begin
         if ({2'b00, lives_q} <= escapes) begin
            lives_d = '0;
            over_d  = 1'b1;
         end else begin
            lives_d = lives_q - escapes[LIVES_W-1:0];
         end
      end

      if (!run) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_COUNT;
               timer_d = SPAWN_PERIOD - 24'd1;
            end
            ST_COUNT: begin
               if (timer_q == 24'd0) begin
                  state_d = ST_PICK;
                  timer_d = SPAWN_PERIOD - 24'd1;
               end else begin
                  timer_d = timer_q - 24'd1;
               end
            end
            ST_PICK: begin
               if (none_free) begin
                  drop_d  = 1'b1;
                  state_d = ST_COUNT;
               end else begin
                  pick_d  = free_idx;
                  state_d = ST_SPAWN;
               end
            end
            ST_SPAWN: begin
               c_en_d[pick_q] = 1'b1;
               x_d[pick_q]    = X_OFFSET + {1'b0, lfsr_q[6:0] & X_MASK};
               state_d        = ST_COUNT;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         timer_q <= SPAWN_PERIOD - 24'd1;
         lfsr_q  <= LFSR_SEED;
         pick_q  <= '0;
         c_en_q  <= '0;
         des_q   <= '0;
         x_q     <= '0;
         kill_q  <= '0;
         lives_q <= LIVES_INIT;
         over_q  <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         lfsr_q  <= lfsr_d;
         pick_q  <= pick_d;
         c_en_q  <= c_en_d;
         des_q   <= des_d;
         x_q     <= x_d;
         kill_q  <= kill_d;
         lives_q <= lives_d;
         over_q  <= over_d;
         drop_q  <= drop_d;
      end
   end

`ifdef DIFFICULTY_RAMP_EN
   logic [1:0] rate_q, rate_d;
   logic [1:0] unused_base_rate;

   assign unused_base_rate = base_rate;

   always_comb begin
      rate_d = (kill_q[7:4] > 4'd3) ? 2'd3 : kill_q[5:4];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) rate_q <= 2'd0;
      else       rate_q <= rate_d;
   end

   assign flying_rate = rate_q;
`else
   assign flying_rate = base_rate;
`endif

   assign c_en       = c_en_q;
   assign des        = des_q;
   assign x_flat     = x_q;
   assign kill_count = kill_q;
   assign lives      = lives_q;
   assign game_over  = over_q;
   assign spawn_drop = drop_q;

endmodule
